// File: rtl/noc_mc_req.sv
// NoC-to-MIG request bridge: buffers incoming NoC packets, decodes read/write
// requests and issues them on the MIG command/write ports with a read-credit limit.

`ifndef IO_WIDTH
`define IO_WIDTH 64
`endif

module noc_mc_req #(
  parameter int IO_WIDTH        = `IO_WIDTH,
  parameter int REQ_DEPTH       = 8,
  parameter int MAX_OUTSTANDING = 64,
  parameter int MIG_ADDR_W      = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IO_WIDTH-1:0]   data_from_noc,
  output logic                  noc_sendok,
  output logic                  mig_cmd_en,
  output logic [2:0]            mig_cmd_instr,
  output logic [MIG_ADDR_W-1:0] mig_cmd_addr,
  output logic [5:0]            mig_cmd_bl,
  input  logic                  mig_cmd_full,
  output logic                  mig_wr_en,
  output logic [31:0]           mig_wr_data,
  output logic [3:0]            mig_wr_mask,
  input  logic                  mig_wr_full,
  input  logic                  rd_data_valid,
  output logic                  addr_valid,
  output logic [IO_WIDTH-1:0]   addr_data,
  output logic [6:0]            rd_outstanding,
  output logic [7:0]            bad_pkt_cnt
);

  // Packet layout, MSB first: SENDBIT | TYPE[2:0] | SRC[3:0] | DATA_A | DATA[31:0]
  localparam int SENDBIT  = IO_WIDTH - 1;
  localparam int TYPE_LSB = IO_WIDTH - 4;
  localparam int DA_LSB   = 32;
  localparam int DA_W     = IO_WIDTH - 8 - DA_LSB;
  localparam logic [2:0] TYPE_RD = 3'd1;
  localparam logic [2:0] TYPE_WR = 3'd2;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_POP     = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_WR_DATA = 3'd3;
  localparam logic [2:0] S_CMD     = 3'd4;

  localparam int PTR_W = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(REQ_DEPTH + 1);

  logic [IO_WIDTH-1:0]   mem_q [REQ_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [IO_WIDTH-1:0]   head_q, pkt_q;
  logic [2:0]            state_q, state_d;
  logic                  fifo_wr, fifo_rd, pkt_load, bad_inc, rd_inc;
  logic                  cmd_en_d, wr_en_d, av_d;
  logic                  cmd_en_q, wr_en_q, av_q;
  logic [2:0]            instr_q;
  logic [MIG_ADDR_W-1:0] cmd_addr, addr_q;
  logic [31:0]           wdata_q;
  logic [IO_WIDTH-1:0]   adata_q;
  logic [6:0]            rd_out_q;
  logic [7:0]            bad_q;
  logic [2:0]            pkt_type;

  assign pkt_type = pkt_q[TYPE_LSB +: 3];

  generate
    if (DA_W >= MIG_ADDR_W) begin : g_addr_trunc
      assign cmd_addr = pkt_q[DA_LSB +: MIG_ADDR_W];
    end else begin : g_addr_zext
      assign cmd_addr = {{(MIG_ADDR_W - DA_W){1'b0}}, pkt_q[DA_LSB +: DA_W]};
    end
  endgenerate

  assign noc_sendok = (count_q < CNT_W'(REQ_DEPTH));
  assign fifo_wr    = data_from_noc[SENDBIT] && noc_sendok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(REQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: storage array has no reset; emptiness is defined by the pointers and
  // count alone, which keeps the array mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= data_from_noc;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (fifo_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (fifo_rd) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
        head_q   <= mem_q[rd_ptr_q];
      end
      case ({fifo_wr, fifo_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    fifo_rd  = 1'b0;
    pkt_load = 1'b0;
    bad_inc  = 1'b0;
    cmd_en_d = 1'b0;
    wr_en_d  = 1'b0;
    av_d     = 1'b0;
    rd_inc   = 1'b0;
    case (state_q)
      S_IDLE: if (count_q != '0) begin
        fifo_rd = 1'b1;
        state_d = S_POP;
      end
      S_POP: begin
        pkt_load = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        if (pkt_type == TYPE_RD)      state_d = S_CMD;
        else if (pkt_type == TYPE_WR) state_d = S_WR_DATA;
        else begin
          bad_inc = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WR_DATA: if (!mig_wr_full) begin
        wr_en_d = 1'b1;
        state_d = S_CMD;
      end
      S_CMD: begin
        if (pkt_type == TYPE_WR) begin
          if (!mig_cmd_full) begin
            cmd_en_d = 1'b1;
            state_d  = S_IDLE;
          end
        end else if (!mig_cmd_full && (rd_out_q < 7'(MAX_OUTSTANDING))) begin
          cmd_en_d = 1'b1;
          av_d     = 1'b1;
          rd_inc   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pkt_q    <= '0;
      cmd_en_q <= 1'b0;
      wr_en_q  <= 1'b0;
      av_q     <= 1'b0;
      instr_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      adata_q  <= '0;
      rd_out_q <= '0;
      bad_q    <= '0;
    end else begin
      state_q  <= state_d;
      cmd_en_q <= cmd_en_d;
      wr_en_q  <= wr_en_d;
      av_q     <= av_d;
      if (pkt_load) pkt_q <= head_q;
      if (cmd_en_d) begin
        instr_q <= (pkt_type == TYPE_WR) ? 3'b000 : 3'b001;
        addr_q  <= cmd_addr;
      end
      if (wr_en_d) wdata_q <= pkt_q[31:0];
      if (av_d)    adata_q <= pkt_q;
      // A grant and a returning word in the same cycle cancel out.
      if (rd_inc && !rd_data_valid)                        rd_out_q <= rd_out_q + 1'b1;
      else if (!rd_inc && rd_data_valid && rd_out_q != '0) rd_out_q <= rd_out_q - 1'b1;
      if (bad_inc && bad_q != 8'hFF) bad_q <= bad_q + 1'b1;
    end
  end

  assign mig_cmd_en     = cmd_en_q;
  assign mig_cmd_instr  = instr_q;
  assign mig_cmd_addr   = addr_q;
  assign mig_cmd_bl     = 6'd0;
  assign mig_wr_en      = wr_en_q;
  assign mig_wr_data    = wdata_q;
  assign mig_wr_mask    = 4'd0;
  assign addr_valid     = av_q;
  assign addr_data      = adata_q;
  assign rd_outstanding = rd_out_q;
  assign bad_pkt_cnt    = bad_q;

endmodule

// File: tb/tb_noc_mc_req.sv
// Self-checking bench for noc_mc_req: vector table plus scoreboard of expected
// MIG commands, with directed sequences for backpressure, limits and reset.

module tb_noc_mc_req;

  localparam logic [2:0] T_RD  = 3'd1;
  localparam logic [2:0] T_WR  = 3'd2;
  localparam logic [2:0] T_BAD = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] data_from_noc;
  logic        noc_sendok;
  logic        mig_cmd_en;
  logic [2:0]  mig_cmd_instr;
  logic [29:0] mig_cmd_addr;
  logic [5:0]  mig_cmd_bl;
  logic        mig_cmd_full;
  logic        mig_wr_en;
  logic [31:0] mig_wr_data;
  logic [3:0]  mig_wr_mask;
  logic        mig_wr_full;
  logic        rd_data_valid;
  logic        addr_valid;
  logic [63:0] addr_data;
  logic [6:0]  rd_outstanding;
  logic [7:0]  bad_pkt_cnt;

  always #5 clk = ~clk;

  noc_mc_req dut (
    .clk(clk), .rst(rst), .data_from_noc(data_from_noc), .noc_sendok(noc_sendok),
    .mig_cmd_en(mig_cmd_en), .mig_cmd_instr(mig_cmd_instr), .mig_cmd_addr(mig_cmd_addr),
    .mig_cmd_bl(mig_cmd_bl), .mig_cmd_full(mig_cmd_full), .mig_wr_en(mig_wr_en),
    .mig_wr_data(mig_wr_data), .mig_wr_mask(mig_wr_mask), .mig_wr_full(mig_wr_full),
    .rd_data_valid(rd_data_valid), .addr_valid(addr_valid), .addr_data(addr_data),
    .rd_outstanding(rd_outstanding), .bad_pkt_cnt(bad_pkt_cnt)
  );

  typedef struct {
    logic [2:0]  instr;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic        is_wr;
    logic [63:0] pkt;
    int          lat;
    int          acc_edge;
  } exp_t;

  typedef struct {
    logic [2:0]  typ;
    logic [23:0] addr;
    logic [31:0] data;
    logic [2:0]  exp_instr;
    int          exp_lat;
    int          exp_out;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   cmd_cnt  = 0;
  int   wr_cnt   = 0;
  bit   wr_seen  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: DUT event with no expected entry (t=%0t)", name, $time);
  endtask

  function automatic logic [63:0] mk_pkt(input logic [2:0] t, input logic [3:0] src,
                                         input logic [23:0] a, input logic [31:0] d);
    return {1'b1, t, src, a, d};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (mig_wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) fail_evt("wr_en");
        else begin
          check("wr_data", mig_wr_data, exp_q[0].wdata);
          check("wr_mask", mig_wr_mask, 4'd0);
          check("wr_for_write", exp_q[0].is_wr, 1'b1);
          wr_seen = 1'b1;
        end
      end
      if (mig_cmd_en) begin
        cmd_cnt++;
        if (exp_q.size() == 0) fail_evt("cmd_en");
        else begin
          mon_e = exp_q.pop_front();
          check("cmd_instr", mig_cmd_instr, mon_e.instr);
          check("cmd_addr", mig_cmd_addr, mon_e.addr);
          check("cmd_bl", mig_cmd_bl, 6'd0);
          check("addr_valid", addr_valid, !mon_e.is_wr);
          if (!mon_e.is_wr) check("addr_data", addr_data, mon_e.pkt);
          else check("wr_before_cmd", wr_seen, 1'b1);
          if (mon_e.lat != 0) check("latency", cyc - mon_e.acc_edge, mon_e.lat);
          wr_seen = 1'b0;
        end
      end else if (addr_valid) begin
        fail_evt("addr_valid_without_cmd");
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] pkt, input bit push, input int lat, output bit acc);
    exp_t e;
    @(negedge clk);
    data_from_noc = pkt;
    acc = noc_sendok;
    if (acc && push) begin
      e.instr    = (pkt[62:60] == T_WR) ? 3'b000 : 3'b001;
      e.addr     = {6'd0, pkt[55:32]};
      e.wdata    = pkt[31:0];
      e.is_wr    = (pkt[62:60] == T_WR);
      e.pkt      = pkt;
      e.lat      = lat;
      e.acc_edge = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 data_from_noc = '0;
  endtask

  task automatic send_retry(input logic [63:0] pkt, input bit push);
    bit acc = 1'b0;
    int k = 0;
    while (!acc && k < 200) begin
      send(pkt, push, 0, acc);
      k++;
    end
    check("send_retry_accepted", acc, 1'b1);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check("drain", exp_q.size(), 0);
    repeat (2) tick();
  endtask

  task automatic pulse_rdv(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rd_data_valid = 1'b1;
      @(posedge clk);
      #1 rd_data_valid = 1'b0;
    end
  endtask

  vec_t vecs[5];
  bit   acc;
  int   base_cmd, base_wr, n_acc, k;
  int   exp_out;

  initial begin
    vecs[0] = '{T_RD, 24'h000100, 32'h0,        3'b001, 4, 1};
    vecs[1] = '{T_WR, 24'h000040, 32'hDEADBEEF, 3'b000, 5, 1};
    vecs[2] = '{T_RD, 24'hFFFFFF, 32'h12345678, 3'b001, 4, 2};
    vecs[3] = '{T_WR, 24'h123456, 32'h0,        3'b000, 5, 2};
    vecs[4] = '{T_RD, 24'h000000, 32'hFFFFFFFF, 3'b001, 4, 3};

    rst = 1'b0;
    data_from_noc = '0;
    mig_cmd_full = 1'b0;
    mig_wr_full = 1'b0;
    rd_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    tick();
    check("rst_sendok", noc_sendok, 1'b1);
    check("rst_cmd_en", mig_cmd_en, 1'b0);
    check("rst_addr_valid", addr_valid, 1'b0);
    check("rst_outstanding", rd_outstanding, 7'd0);
    check("rst_bad_cnt", bad_pkt_cnt, 8'd0);

    // Single transactions with an idle MIG.
    for (int i = 0; i < 5; i++) begin
      send(mk_pkt(vecs[i].typ, 4'd3, vecs[i].addr, vecs[i].data), 1'b1, vecs[i].exp_lat, acc);
      check("vec_accept", acc, 1'b1);
      check("vec_instr_tbl", exp_q[0].instr, vecs[i].exp_instr);
      wait_done(40);
      check("vec_outstanding", rd_outstanding, 7'(vecs[i].exp_out));
    end
    exp_out = 3;
    pulse_rdv(4);
    check("rdv_drain_floor", rd_outstanding, 7'd0);
    exp_out = 0;

    // Write-data backpressure.
    mig_wr_full = 1'b1;
    base_wr = wr_cnt;
    base_cmd = cmd_cnt;
    send(mk_pkt(T_WR, 4'd1, 24'h000200, 32'hDEADBEEF), 1'b1, 0, acc);
    repeat (8) tick();
    check("wrfull_no_wr_en", wr_cnt - base_wr, 0);
    check("wrfull_no_cmd", cmd_cnt - base_cmd, 0);
    mig_wr_full = 1'b0;
    wait_done(40);
    check("wrfull_wr_once", wr_cnt - base_wr, 1);

    // Fill the request FIFO while the command port is blocked.
    mig_cmd_full = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      send(mk_pkt((i % 2 == 0) ? T_RD : T_WR, 4'(i), 24'(24'h300 + i), 32'(32'hA000 + i)),
           1'b1, 0, acc);
      if (acc) n_acc++;
      if (acc && i % 2 == 0) exp_out++;
    end
    check("fill_last_refused", acc, 1'b0);
    check("fill_accepted", n_acc, 9);
    check("fill_sendok_low", noc_sendok, 1'b0);
    mig_cmd_full = 1'b0;
    wait_done(300);
    check("fill_outstanding", rd_outstanding, 7'(exp_out));
    pulse_rdv(exp_out);
    check("fill_drained", rd_outstanding, 7'd0);

    // Read credit limit.
    base_cmd = cmd_cnt;
    for (int i = 0; i < 65; i++) send_retry(mk_pkt(T_RD, 4'd2, 24'(i), 32'h0), 1'b1);
    k = 0;
    while ((cmd_cnt - base_cmd) < 64 && k < 1500) begin
      tick();
      k++;
    end
    repeat (10) tick();
    check("lim_cmd_count", cmd_cnt - base_cmd, 64);
    check("lim_outstanding", rd_outstanding, 7'd64);
    check("lim_one_pending", exp_q.size(), 1);
    @(negedge clk);
    rd_data_valid = 1'b1;
    @(posedge clk);
    #1 rd_data_valid = 1'b0;
    tick();
    check("lim_not_yet", mig_cmd_en, 1'b0);
    check("lim_out_63", rd_outstanding, 7'd63);
    tick();
    check("lim_65th_issue", mig_cmd_en, 1'b1);
    check("lim_out_64", rd_outstanding, 7'd64);

    // Grant and returning word in the same cycle.
    send(mk_pkt(T_RD, 4'd4, 24'h000777, 32'h0), 1'b1, 0, acc);
    repeat (8) tick();
    check("incdec_stalled", exp_q.size(), 1);
    @(negedge clk);
    rd_data_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rd_data_valid = 1'b0;
    tick();
    check("incdec_issue", mig_cmd_en, 1'b1);
    check("incdec_out", rd_outstanding, 7'd63);

    // Unknown TYPE followed by a read.
    send(mk_pkt(T_BAD, 4'd5, 24'h000050, 32'h1), 1'b0, 0, acc);
    send(mk_pkt(T_RD, 4'd5, 24'h000060, 32'h2), 1'b1, 0, acc);
    wait_done(40);
    check("bad_cnt", bad_pkt_cnt, 8'd1);
    check("bad_then_read_out", rd_outstanding, 7'd64);

    // Reset while a write waits in WR_DATA with three packets queued.
    mig_wr_full = 1'b1;
    send(mk_pkt(T_WR, 4'd6, 24'h000400, 32'hCAFEF00D), 1'b1, 0, acc);
    for (int i = 0; i < 3; i++) send(mk_pkt(T_RD, 4'd6, 24'(24'h500 + i), 32'h0), 1'b1, 0, acc);
    repeat (6) tick();
    check("pre_rst_queued", exp_q.size(), 4);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_cmd_en", mig_cmd_en, 1'b0);
    check("arst_wr_en", mig_wr_en, 1'b0);
    check("arst_addr_valid", addr_valid, 1'b0);
    check("arst_instr", mig_cmd_instr, 3'd0);
    check("arst_addr", mig_cmd_addr, 30'd0);
    check("arst_wdata", mig_wr_data, 32'd0);
    check("arst_addr_data", addr_data, 64'd0);
    check("arst_outstanding", rd_outstanding, 7'd0);
    check("arst_bad_cnt", bad_pkt_cnt, 8'd0);
    exp_q.delete();
    wr_seen = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mig_wr_full = 1'b0;
    base_cmd = cmd_cnt;
    base_wr = wr_cnt;
    repeat (20) tick();
    check("post_rst_no_cmd", cmd_cnt - base_cmd, 0);
    check("post_rst_no_wr", wr_cnt - base_wr, 0);
    check("post_rst_sendok", noc_sendok, 1'b1);
    send(mk_pkt(T_RD, 4'd3, 24'h000100, 32'h0), 1'b1, 4, acc);
    wait_done(40);
    check("post_rst_read_out", rd_outstanding, 7'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
